// File: rtl/sr_vcu_pkg.sv
// Shared definitions for the schoolRISCV-to-VCU bridge: status word layout and read-path states.
package sr_vcu_pkg;

  localparam int SR_VCU_ST_OVR  = 31;
  localparam int SR_VCU_ST_NEW  = 30;
  localparam int SR_VCU_ST_LVLW = 4;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_NEW  = 1'b1
  } rd_state_t;

endpackage

// File: rtl/sr_vcu_fifo.sv
// Show-ahead FIFO for one bridge channel; the head entry is presented on dout while not empty.
module sr_vcu_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              din,
  input  logic                       pop,
  output logic [DW-1:0]              dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  // A push is refused when full even if a pop happens in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sr_vcu_bridge.sv
// Bridge from CPU register writes (BASE_REG..BASE_REG+CH-1) to per-channel VCU FIFOs plus read capture.
// Optional status word enabled with `define SR_VCU_STATUS_EN.
module sr_vcu_bridge
  import sr_vcu_pkg::*;
#(
  parameter int CH       = 2,
  parameter int DW       = 32,
  parameter int DEPTH    = 4,
  parameter int BASE_REG = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_we,
  input  logic [4:0]         cpu_rd,
  input  logic [DW-1:0]      cpu_wd,
  output logic               cpu_stall,
  output logic [CH*DW-1:0]   ch_data,
  output logic [CH-1:0]      ch_valid,
  input  logic [CH-1:0]      ch_ready,
  input  logic [DW-1:0]      vcu_rdata,
  input  logic               vcu_rvalid,
  output logic [DW-1:0]      cpu_rdata,
  output logic               cpu_rdata_new,
  input  logic               cpu_rack,
  output logic [31:0]        status
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [CH-1:0] hit;
  logic [CH-1:0] push;
  logic [CH-1:0] pop;
  logic [CH-1:0] full;
  logic [CH-1:0] empty;
  logic [LW-1:0] lvl [CH];

  rd_state_t rd_state;
  rd_state_t rd_state_nxt;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign hit[i]  = cpu_we && (cpu_rd == 5'(BASE_REG + i));
    assign push[i] = hit[i] && (lvl[i] != LW'(DEPTH));
    assign pop[i]  = ~empty[i] & ch_ready[i];

    sr_vcu_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .din   (cpu_wd),
      .pop   (pop[i]),
      .dout  (ch_data[i*DW +: DW]),
      .full  (full[i]),
      .empty (empty[i]),
      .level (lvl[i])
    );
  end

  assign ch_valid  = ~empty;
  assign cpu_stall = |(hit & full);

  always_ff @(posedge clk) begin
    if (!rst_n) rd_state <= RD_IDLE;
    else        rd_state <= rd_state_nxt;
  end

  // New read data takes priority over an acknowledge in the same cycle.
  always_comb begin
    rd_state_nxt = rd_state;
    if (vcu_rvalid)    rd_state_nxt = RD_NEW;
    else if (cpu_rack) rd_state_nxt = RD_IDLE;
  end

  assign cpu_rdata_new = (rd_state == RD_NEW);

  always_ff @(posedge clk) begin
    if (!rst_n)          cpu_rdata <= '0;
    else if (vcu_rvalid) cpu_rdata <= vcu_rdata;
  end

`ifdef SR_VCU_STATUS_EN
  localparam int NLVL = (CH < 7) ? CH : 7;

  logic        overrun;
  logic [31:0] status_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) overrun <= 1'b0;
    else        overrun <= overrun | (vcu_rvalid & (rd_state == RD_NEW) & ~cpu_rack);
  end

  always_comb begin
    status_nxt = '0;
    status_nxt[SR_VCU_ST_OVR] = overrun;
    status_nxt[SR_VCU_ST_NEW] = cpu_rdata_new;
    for (int i = 0; i < NLVL; i++) begin
      status_nxt[SR_VCU_ST_LVLW*i +: SR_VCU_ST_LVLW] = SR_VCU_ST_LVLW'(lvl[i]);
    end
  end

  // Snapshot of the previous cycle's internal state.
  always_ff @(posedge clk) begin
    if (!rst_n) status <= '0;
    else        status <= status_nxt;
  end
`else
  assign status = '0;
`endif

endmodule
